// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: steps the datapath through the
// initial AddRoundKey, NR rounds and result capture, then holds the block until it is consumed.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  output logic         busy,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic         dp_final,
  output logic [3:0]   round_idx,
  output logic [7:0]   rcon,
  input  logic [127:0] dp_state,
  output logic [127:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  blk_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    CAPTURE,
    OUT
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   data_q;
  logic [15:0]    blkCount_q;
  logic           handshake;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // The result register only listens to the datapath during CAPTURE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= 128'd0;
    end else if (state_q == CAPTURE) begin
      data_q <= dp_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blkCount_q <= 16'd0;
    end else if (handshake) begin
      blkCount_q <= blkCount_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    round_idx   = 4'd0;
    rcon        = 8'h00;
    out_valid   = 1'b0;
    handshake   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        dp_load = 1'b1;
        round_d = 4'd1;
        rcon_d  = 8'h01;
        state_d = (NR == 1) ? FINAL : ROUND;
      end
      ROUND: begin
        busy        = 1'b1;
        dp_round_en = 1'b1;
        round_idx   = round_q;
        rcon        = rcon_q;
        round_d     = round_q + 4'd1;
        // GF(2^8) doubling gives the next round constant.
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        if (round_q == 4'(NR - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        busy        = 1'b1;
        dp_round_en = 1'b1;
        dp_final    = 1'b1;
        round_idx   = round_q;
        rcon        = rcon_q;
        round_d     = 4'd0;
        rcon_d      = 8'h00;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        busy    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out  = data_q;
  assign blk_count = blkCount_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized self-checking bench for aes_round_ctrl: an NR=10 and an NR=1 instance
// compared against a cycle-offset model of the round schedule.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] AES_VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, out_ready;
  logic [127:0] dp_state;
  logic         in_ready, busy, dp_load, dp_round_en, dp_final, out_valid;
  logic [3:0]   round_idx;
  logic [7:0]   rcon;
  logic [127:0] data_out;
  logic [15:0]  blk_count;

  logic         start1, out_ready1;
  logic [127:0] dp_state1;
  logic         in_ready1, busy1, dp_load1, dp_round_en1, dp_final1, out_valid1;
  logic [3:0]   round_idx1;
  logic [7:0]   rcon1;
  logic [127:0] data_out1;
  logic [15:0]  blk_count1;

  int           nCompared = 0;
  int           nMismatch = 0;
  logic [15:0]  expCount = 16'd0;

  logic [17:0]  ctrl10, ctrl1;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready), .busy(busy),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_final(dp_final),
    .round_idx(round_idx), .rcon(rcon), .dp_state(dp_state), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .blk_count(blk_count)
  );

  aes_round_ctrl #(.NR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_ready(in_ready1), .busy(busy1),
    .dp_load(dp_load1), .dp_round_en(dp_round_en1), .dp_final(dp_final1),
    .round_idx(round_idx1), .rcon(rcon1), .dp_state(dp_state1), .data_out(data_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .blk_count(blk_count1)
  );

  assign ctrl10 = {in_ready, busy, dp_load, dp_round_en, dp_final, round_idx, rcon, out_valid};
  assign ctrl1  = {in_ready1, busy1, dp_load1, dp_round_en1, dp_final1, round_idx1, rcon1, out_valid1};

  // Round constant for round r: x^(r-1) in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] rcon_of(int r);
    int v = 0;
    if (r > 0) begin
      v = 1;
      for (int i = 1; i < r; i++) begin
        v = v * 2;
        if (v > 255) v = v ^ 'h11B;
      end
    end
    return 8'(v);
  endfunction

  // Expected control bundle k cycles after start acceptance (k=0 means idle).
  function automatic logic [17:0] exp_ctrl(int nr, int k);
    logic ir = 1'b0, bz = 1'b0, ld = 1'b0, re = 1'b0, fi = 1'b0, ov = 1'b0;
    logic [3:0] idx = 4'd0;
    logic [7:0] rc = 8'h00;
    if (k == 0) begin
      ir = 1'b1;
    end else begin
      bz = 1'b1;
      if (k == 1) begin
        ld = 1'b1;
      end else if (k <= nr) begin
        re  = 1'b1;
        idx = 4'(k - 1);
        rc  = rcon_of(k - 1);
      end else if (k == nr + 1) begin
        re  = 1'b1;
        fi  = 1'b1;
        idx = 4'(nr);
        rc  = rcon_of(nr);
      end else if (k >= nr + 3) begin
        ov = 1'b1;
      end
    end
    return {ir, bz, ld, re, fi, idx, rc, ov};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_block(input logic [127:0] capVal, input int waitCycles);
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatch++;
      $display("[TB] FAIL rb_in_ready: got %b expected 1", in_ready);
    end
    start     = 1'b1;
    out_ready = 1'($urandom % 2);
    step();
    for (int k = 1; k <= NR + 3 + waitCycles; k++) begin
      nCompared++;
      if (ctrl10 !== exp_ctrl(NR, k)) begin
        nMismatch++;
        $display("[TB] FAIL rb_ctrl k=%0d: got %h expected %h", k, ctrl10, exp_ctrl(NR, k));
      end
      if (k >= NR + 3) begin
        nCompared++;
        if (data_out !== capVal || blk_count !== expCount) begin
          nMismatch++;
          $display("[TB] FAIL rb_out k=%0d: got data %h cnt %h expected data %h cnt %h",
                   k, data_out, blk_count, capVal, expCount);
        end
      end
      start     = 1'($urandom % 2);
      dp_state  = (k == NR + 2) ? capVal : rand128();
      out_ready = (k >= NR + 3) ? (k == NR + 3 + waitCycles) : 1'($urandom % 2);
      step();
    end
    expCount++;
    nCompared++;
    if (ctrl10 !== exp_ctrl(NR, 0) || blk_count !== expCount) begin
      nMismatch++;
      $display("[TB] FAIL rb_done: got ctrl %h cnt %h expected ctrl %h cnt %h",
               ctrl10, blk_count, exp_ctrl(NR, 0), expCount);
    end
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; start1 = 1'b1; out_ready1 = 1'b1;
    dp_state = rand128(); dp_state1 = rand128();
    step(); step();
    nCompared++;
    if (ctrl10 !== exp_ctrl(NR, 0) || data_out !== 128'd0 || blk_count !== 16'd0) begin
      nMismatch++;
      $display("[TB] FAIL reset10: got ctrl %h data %h cnt %h expected ctrl %h data 0 cnt 0",
               ctrl10, data_out, blk_count, exp_ctrl(NR, 0));
    end
    nCompared++;
    if (ctrl1 !== exp_ctrl(1, 0) || data_out1 !== 128'd0 || blk_count1 !== 16'd0) begin
      nMismatch++;
      $display("[TB] FAIL reset1: got ctrl %h data %h cnt %h expected ctrl %h data 0 cnt 0",
               ctrl1, data_out1, blk_count1, exp_ctrl(1, 0));
    end
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; out_ready1 = 1'b0;
    step();
    expCount = 16'd0;
  endtask

  task automatic test_single_block();
    run_block(AES_VEC, 20);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    nCompared++;
    if (blk_count !== expCount || ctrl10 !== exp_ctrl(NR, 0)) begin
      nMismatch++;
      $display("[TB] FAIL stray_ready: got cnt %h ctrl %h expected cnt %h ctrl %h",
               blk_count, ctrl10, expCount, exp_ctrl(NR, 0));
    end
  endtask

  task automatic test_reset_midround();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      nCompared++;
      if (ctrl10 !== exp_ctrl(NR, k)) begin
        nMismatch++;
        $display("[TB] FAIL mid_ctrl k=%0d: got %h expected %h", k, ctrl10, exp_ctrl(NR, k));
      end
      if (k < 6) step();
    end
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
    step();
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    expCount = 16'd0;
    nCompared++;
    if (ctrl10 !== exp_ctrl(NR, 0) || data_out !== 128'd0 || blk_count !== 16'd0) begin
      nMismatch++;
      $display("[TB] FAIL mid_reset: got ctrl %h data %h cnt %h expected ctrl %h data 0 cnt 0",
               ctrl10, data_out, blk_count, exp_ctrl(NR, 0));
    end
    run_block(rand128(), 2);
    // Abort a block that is waiting in OUT; the unconsumed result is discarded.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (NR + 2) step();
    nCompared++;
    if (out_valid !== 1'b1) begin
      nMismatch++;
      $display("[TB] FAIL out_before_reset: got %b expected 1", out_valid);
    end
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1; out_ready = 1'b0;
    expCount = 16'd0;
    nCompared++;
    if (ctrl10 !== exp_ctrl(NR, 0) || data_out !== 128'd0 || blk_count !== 16'd0) begin
      nMismatch++;
      $display("[TB] FAIL out_reset: got ctrl %h data %h cnt %h expected ctrl %h data 0 cnt 0",
               ctrl10, data_out, blk_count, exp_ctrl(NR, 0));
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 6; b++) begin
      run_block(rand128(), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_wrap();
    force dut.blkCount_q = 16'hFFFF;
    step();
    release dut.blkCount_q;
    step();
    expCount = 16'hFFFF;
    nCompared++;
    if (blk_count !== 16'hFFFF) begin
      nMismatch++;
      $display("[TB] FAIL wrap_preload: got %h expected ffff", blk_count);
    end
    run_block(rand128(), 1);
    nCompared++;
    if (blk_count !== 16'h0000) begin
      nMismatch++;
      $display("[TB] FAIL wrap: got %h expected 0000", blk_count);
    end
  endtask

  task automatic test_nr1();
    logic [127:0] val;
    val = rand128();
    nCompared++;
    if (ctrl1 !== exp_ctrl(1, 0)) begin
      nMismatch++;
      $display("[TB] FAIL nr1_idle: got %h expected %h", ctrl1, exp_ctrl(1, 0));
    end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      nCompared++;
      if (ctrl1 !== exp_ctrl(1, k)) begin
        nMismatch++;
        $display("[TB] FAIL nr1_ctrl k=%0d: got %h expected %h", k, ctrl1, exp_ctrl(1, k));
      end
      if (k == 4) begin
        nCompared++;
        if (data_out1 !== val) begin
          nMismatch++;
          $display("[TB] FAIL nr1_data: got %h expected %h", data_out1, val);
        end
      end
      dp_state1  = (k == 3) ? val : rand128();
      out_ready1 = (k == 4);
      step();
    end
    out_ready1 = 1'b0;
    nCompared++;
    if (ctrl1 !== exp_ctrl(1, 0) || blk_count1 !== 16'd1) begin
      nMismatch++;
      $display("[TB] FAIL nr1_done: got ctrl %h cnt %h expected ctrl %h cnt 0001",
               ctrl1, blk_count1, exp_ctrl(1, 0));
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_reset_midround();
    test_back_to_back();
    test_wrap();
    test_nr1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
